// File: rtl/csam_mul_seq.sv
// Sequencer that builds an AW x BW product from one shared XW x YW CSAM multiplier,
// feeding one partial product per cycle and shift-accumulating the results.
module csam_mul_seq #(
    parameter int XW = 8,
    parameter int YW = 4,
    parameter int NX = 2,
    parameter int NY = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NX*XW-1:0]            a,
    input  logic [NY*YW-1:0]            b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NX*XW+NY*YW-1:0]      product,
    output logic [XW-1:0]               csam_x,
    output logic [YW-1:0]               csam_y,
    input  logic [XW+YW-1:0]            csam_p,
    output logic                        busy
);

    localparam int AW = NX * XW;
    localparam int BW = NY * YW;
    localparam int PW = AW + BW;
    localparam int CW = XW + YW;
    localparam int NK = NX * NY;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [PW-1:0]   product_q;
    logic [PW-1:0]   pp_aligned;
    int              ci;
    int              cj;

    // Place a CSAM partial product at its weight inside the full-width accumulator.
    function automatic logic [PW-1:0] align_pp(input logic [CW-1:0] p, input int sh);
        logic [PW-1:0] ext;
        ext = '0;
        ext[CW-1:0] = p;
        return ext << sh;
    endfunction

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        csam_x     = '0;
        csam_y     = '0;
        ci         = 0;
        cj         = 0;
        pp_aligned = '0;
        case (state)
            IDLE: begin
                in_ready = reset_n;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                // A chunk index runs fastest, B chunk index advances every NX steps.
                ci         = int'(k) % NX;
                cj         = int'(k) / NX;
                csam_x     = a_q[ci*XW +: XW];
                csam_y     = b_q[cj*YW +: YW];
                pp_aligned = align_pp(csam_p, ci*XW + cj*YW);
                if (k == K_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign acc_nxt = acc + pp_aligned;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    if (k == K_LAST) begin
                        k         <= '0;
                        product_q <= acc_nxt;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = product_q;
    assign busy    = (state == MUL) || (state == DONE);

endmodule

// File: tb/tb_csam_mul_seq.sv
// Directed bench for csam_mul_seq with a behavioural 8x4 CSAM attached to the csam_* ports.
module tb_csam_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] product;
    logic [7:0]  csam_x;
    logic [3:0]  csam_y;
    logic [11:0] csam_p;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    csam_mul_seq #(.XW(8), .YW(4), .NX(2), .NY(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .csam_x    (csam_x),
        .csam_y    (csam_y),
        .csam_p    (csam_p),
        .busy      (busy)
    );

    // External combinational CSAM
    assign csam_p = 12'(csam_x) * 12'(csam_y);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Accepts one job with out_ready high and checks latency, result and single-cycle out_valid.
    task automatic run_job(input logic [15:0] va, input logic [7:0] vb, input logic [23:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("job_in_ready", 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("job_latency", 32'(n), 32'd4);
        chk("job_product", 32'(product), 32'(exp));
        step();
        chk("job_ov_drop", 32'(out_valid), 32'd0);
        chk("job_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        int acc_t [4];
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [23:0] rexp;

        vecs[0] = '{16'hFFFF, 8'hFF, 24'hFEFF01};
        vecs[1] = '{16'h1234, 8'h56, 24'h061D78};
        vecs[2] = '{16'h0000, 8'hFF, 24'h000000};
        vecs[3] = '{16'hABCD, 8'h96, 24'h64AA1E};
        vecs[4] = '{16'h0001, 8'h01, 24'h000001};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        step(); step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_csam_x", 32'(csam_x), 32'd0);
        chk("rst_csam_y", 32'(csam_y), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Partial-product sequence for 0xABCD * 0x96
        a = 16'hABCD; b = 8'h96; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("seq_busy", 32'(busy), 32'd1);
        chk("seq_in_ready", 32'(in_ready), 32'd0);
        chk("seq0", {20'd0, csam_x, csam_y}, 32'hCD6);
        step();
        chk("seq1", {20'd0, csam_x, csam_y}, 32'hAB6);
        step();
        chk("seq2", {20'd0, csam_x, csam_y}, 32'hCD9);
        step();
        chk("seq3", {20'd0, csam_x, csam_y}, 32'hAB9);
        chk("seq_ov_low", 32'(out_valid), 32'd0);
        step();
        chk("seq_out_valid", 32'(out_valid), 32'd1);
        chk("seq_product", 32'(product), 32'h64AA1E);
        chk("done_csam_x", 32'(csam_x), 32'd0);
        chk("done_csam_y", 32'(csam_y), 32'd0);
        out_ready = 1'b1;
        step();
        chk("seq_release", 32'(out_valid), 32'd0);
        chk("seq_hold_idle", 32'(product), 32'h64AA1E);
        chk("seq_idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_job(vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure with a competing request during DONE
        a = 16'h1234; b = 8'h56; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        a = 16'h0001; b = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_product", 32'(product), 32'h061D78);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        chk("bp_still_product", 32'(product), 32'h061D78);
        step();
        chk("bp_released", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_not_taken", 32'(busy), 32'd0);
        step();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp2_latency", 32'(n), 32'd4);
        chk("bp2_product", 32'(product), 32'h000001);
        step();

        // Reset on the second MUL cycle abandons the job
        a = 16'hABCD; b = 8'h96; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_in_mul", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_product", 32'(product), 32'd0);
        chk("mid_csam_x", 32'(csam_x), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid || busy) seen++;
        end
        chk("mid_no_result", 32'(seen), 32'd0);
        chk("mid_product_zero", 32'(product), 32'd0);

        // Back-to-back stream with in_valid held high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(0, 255));
            rexp = 24'(ra) * 24'(rb);
            a = ra; b = rb; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                step();
                n++;
            end
            chk("str_ready", 32'(in_ready), 32'd1);
            acc_t[i] = cyc;
            step();
            n = 0;
            while (!out_valid && n < 20) begin
                chk("str_mul_ready_low", 32'(in_ready), 32'd0);
                step();
                n++;
            end
            chk("str_latency", 32'(n), 32'd4);
            chk("str_done_ready_low", 32'(in_ready), 32'd0);
            chk("str_product", 32'(product), 32'(rexp));
            step();
            if (i > 0) chk("str_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd6);
        end
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
